bus_arbiter_rr8: RTL

Round-robin arbiter sharing one 32-bit datapath resource (shared bus or memory port) among up to eight requesters. It produces the 3-bit select that steers the 8:1 32-bit word multiplexer in front of the resource, plus a one-hot grant back to the requesters. A grant is held until the owner signals completion, withdraws its request, or exceeds a programmable hold limit.

---
 rtl/bus_arbiter_rr8.sv | 98 +++++++++
 1 files changed

// File: rtl/bus_arbiter_rr8.sv
// Round-robin arbiter for eight requesters sharing one 32-bit resource.
// Holds a grant until done, request withdrawal, or the MAX_HOLD limit.
module bus_arbiter_rr8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] sel_n;
    logic [2:0] win;
    logic [7:0] grant_n;
    logic [7:0] hold, hold_n;
    logic       timeout_n;
    logic       found;
    logic       release_now;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                found = 1'b1;
                win   = ptr + 3'(i);
            end
        end
    end

    assign release_now = done || !req[sel] || (hold == HOLD_LAST);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel;
        grant_n   = grant;
        hold_n    = hold;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    sel_n   = win;
                    grant_n = 8'b1 << win;
                    hold_n  = 8'd0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_n   = IDLE;
                    grant_n   = 8'd0;
                    ptr_n     = sel + 3'd1;
                    // Only a pure hold-limit release reports a timeout.
                    timeout_n = !done && req[sel];
                end else begin
                    hold_n = hold + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            sel     <= 3'd0;
            grant   <= 8'd0;
            hold    <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            sel     <= sel_n;
            grant   <= grant_n;
            hold    <= hold_n;
            timeout <= timeout_n;
        end
    end

    assign busy = (state == BUSY);

endmodule
